prog_counter: RTL

- Parametrised, programmable successor to the free-running 8-bit counter used in our TinyTapeout projects.
- Adds the following over a plain counter: width generic, enable, direction, programmable terminal limit, prescaler, synchronous clear/load, and wrap/saturate/one-shot modes with a terminal-count pulse.
- Instantiated inside a tt_um_* wrapper; count drives uo_out/uio_out; controls come from ui_in/uio_in.

---
 rtl/prog_counter_pkg.sv | 14 +
 rtl/tick_prescaler.sv | 29 ++
 rtl/prog_counter.sv | 94 +++++++++
 3 files changed

// File: rtl/prog_counter_pkg.sv
// Shared encodings for the programmable counter: count modes and one-shot FSM states.
package prog_counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Enabled-cycle divider: combinational tick when en=1 and pcnt==prescale, pcnt holds while en=0.
// sync_zero restarts the divide period; no backpressure.
module tick_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  sync_zero,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pcnt;

  assign tick = en && (pcnt == prescale);

  // A prescale lowered below pcnt is not caught early: pcnt wraps through its maximum first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (sync_zero) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= tick ? '0 : pcnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with prescaler, wrap/saturate/one-shot modes and registered tc pulse.
// Count updates one cycle after a tick; priority clr > start > load > tick; no backpressure.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  dir,
  input  logic [1:0]            mode,
  input  logic                  start,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  busy,
  output logic                  done
);

  state_t state, state_nxt;
  logic   tick;
  logic   sync_zero;
  logic   oneshot;
  logic   terminal;
  logic   count_ok;
  logic   wrap_mode;

  assign sync_zero = clr | start | load;
  assign oneshot   = (mode == MODE_ONESHOT);
  assign wrap_mode = (mode != MODE_SAT) && !oneshot;
  // >= rather than == so a loaded value above limit is already terminal.
  assign terminal  = dir ? (count >= limit) : (count == '0);
  assign count_ok  = !oneshot || (state == ST_RUN);

  tick_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_tick_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sync_zero (sync_zero),
    .prescale  (prescale),
    .tick      (tick)
  );

  always_comb begin
    state_nxt = state;
    if (clr || !oneshot) begin
      state_nxt = ST_IDLE;
    end else if (start) begin
      state_nxt = ST_RUN;
    end else if (!load && tick && (state == ST_RUN) && terminal) begin
      state_nxt = ST_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      count <= '0;
      tc    <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ST_RUN);
      done  <= (state_nxt == ST_DONE);
      tc    <= 1'b0;
      if (clr) begin
        count <= '0;
      end else if (start) begin
        count <= dir ? '0 : limit;
      end else if (load) begin
        count <= load_val;
      end else if (tick && count_ok) begin
        if (terminal) begin
          tc <= 1'b1;
          if (wrap_mode) begin
            count <= dir ? '0 : limit;
          end
        end else begin
          count <= dir ? count + WIDTH'(1) : count - WIDTH'(1);
        end
      end
    end
  end

endmodule
